vec_splice_pipe: RTL

- Parametrised, pipelined successor to the fixed 64-bit vector-append datapath.
- Builds each output word from three fields: a head taken from operand A, optionally lane-reversed; a gap of fill lanes; and a tail taken from operand B.
- Adds valid/ready streaming with full-throughput backpressure, a per-beat mode, and packet framing.
- Sits between the operand fetch stream and the downstream packer.

---
 rtl/vec_splice_pkg.sv | 18 +
 rtl/vec_splice_stage.sv | 35 +++
 rtl/vec_splice_pipe.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/vec_splice_pkg.sv
// rtl/vec_splice_pkg.sv - shared types and constants for the vec_splice pipeline
// Ports: none (package). Provides mode_t, MODE_* encodings and STAT_W.
package vec_splice_pkg;

  // Per-beat mode. bit1 selects fill for the gap, bit0 reverses head lanes.
  typedef struct packed {
    logic fill_en;
    logic rev_en;
  } mode_t;

  localparam logic [1:0] MODE_PASS     = 2'b00;
  localparam logic [1:0] MODE_REV      = 2'b01;
  localparam logic [1:0] MODE_FILL     = 2'b10;
  localparam logic [1:0] MODE_REV_FILL = 2'b11;

  localparam int STAT_W = 32;

endpackage

// File: rtl/vec_splice_stage.sv
// rtl/vec_splice_stage.sv - one valid/ready register slice of parametrised width
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     upstream handshake; in_data captured on handshake
//   out_valid/out_ready   downstream handshake; out_data is the register
// in_ready is combinational from out_ready so a full slice can drain and
// refill in the same cycle (no bubble).
module vec_splice_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_valid && in_ready) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/vec_splice_pipe.sv
// rtl/vec_splice_pipe.sv - two-stage streaming splice of {head(A), gap, tail(B)}
// Optional statistics counters: define VEC_SPLICE_STATS_EN.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   in_valid/in_ready               input beat handshake
//   in_a, in_b                      operands (IN_LANES*LANE_W)
//   in_mode                         bit0 reverse head lanes, bit1 fill gap
//   in_fill                         gap lane value when bit1 set
//   in_last                         packet framing, travels with the beat
//   out_valid/out_ready             output beat handshake
//   out_data, out_last              spliced word and its framing bit
//   stat_clr                        synchronous clear of counters
//   stat_xfers, stat_stalls         transfer / stall counters (0 when disabled)
module vec_splice_pipe
  import vec_splice_pkg::*;
#(
  parameter int LANE_W     = 8,
  parameter int IN_LANES   = 8,
  parameter int HEAD_LANES = 4,
  parameter int TAIL_LANES = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [IN_LANES*LANE_W-1:0] in_a,
  input  logic [IN_LANES*LANE_W-1:0] in_b,
  input  logic [1:0]                 in_mode,
  input  logic [LANE_W-1:0]          in_fill,
  input  logic                       in_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [IN_LANES*LANE_W-1:0] out_data,
  output logic                       out_last,
  input  logic                       stat_clr,
  output logic [STAT_W-1:0]          stat_xfers,
  output logic [STAT_W-1:0]          stat_stalls
);

  localparam int GAP_LANES = IN_LANES - HEAD_LANES - TAIL_LANES;
  localparam int DW        = IN_LANES * LANE_W;
  localparam int S1W       = 2 * DW + 2 + LANE_W + 1;
  localparam int S2W       = DW + 1;

  generate
    if (GAP_LANES < 0) begin : g_bad_cfg
      $error("vec_splice_pipe: HEAD_LANES + TAIL_LANES exceeds IN_LANES");
    end
  endgenerate

  // ---------------------------------------------------------------- S1
  logic [S1W-1:0]    s1_din;
  logic [S1W-1:0]    s1_q;
  logic              s1_valid;
  logic              s2_ready;
  logic [DW-1:0]     s1_a;
  logic [DW-1:0]     s1_b;
  mode_t             s1_mode;
  logic [LANE_W-1:0] s1_fill;
  logic              s1_last;

  assign s1_din = {in_a, in_b, in_mode, in_fill, in_last};

  vec_splice_stage #(.W(S1W)) u_s1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (s1_din),
    .out_valid (s1_valid),
    .out_ready (s2_ready),
    .out_data  (s1_q)
  );

  assign {s1_a, s1_b, s1_mode, s1_fill, s1_last} = s1_q;

  // ---------------------------------------------------------------- splice
  // Built lane by lane so that GAP_LANES == 0 needs no zero-width replication.
  logic [DW-1:0]     s1_word;
  logic [LANE_W-1:0] gap_lane;

  assign gap_lane = s1_mode.fill_en ? s1_fill : '0;

  generate
    for (genvar i = 0; i < HEAD_LANES; i++) begin : g_head
      // Head lane i swaps with head lane HEAD_LANES-1-i, i.e. A lane IN_LANES-1-i.
      assign s1_word[(IN_LANES-HEAD_LANES+i)*LANE_W +: LANE_W] =
        s1_mode.rev_en ? s1_a[(IN_LANES-1-i)*LANE_W +: LANE_W]
                       : s1_a[(IN_LANES-HEAD_LANES+i)*LANE_W +: LANE_W];
    end
    for (genvar g = 0; g < GAP_LANES; g++) begin : g_gap
      assign s1_word[(TAIL_LANES+g)*LANE_W +: LANE_W] = gap_lane;
    end
    for (genvar t = 0; t < TAIL_LANES; t++) begin : g_tail
      assign s1_word[t*LANE_W +: LANE_W] = s1_b[t*LANE_W +: LANE_W];
    end
  endgenerate

  // Lanes of A/B outside head/tail are intentionally dropped.
  logic unused_operands;
  assign unused_operands = ^{s1_a, s1_b, s1_fill};

  // ---------------------------------------------------------------- S2
  logic [S2W-1:0] s2_q;

  vec_splice_stage #(.W(S2W)) u_s2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (s1_valid),
    .in_ready  (s2_ready),
    .in_data   ({s1_word, s1_last}),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (s2_q)
  );

  assign {out_data, out_last} = s2_q;

  // ---------------------------------------------------------------- stats
`ifdef VEC_SPLICE_STATS_EN
  logic [STAT_W-1:0] xfers_q;
  logic [STAT_W-1:0] stalls_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfers_q  <= '0;
      stalls_q <= '0;
    end else if (stat_clr) begin
      xfers_q  <= '0;
      stalls_q <= '0;
    end else begin
      if (out_valid && out_ready && (xfers_q != '1)) begin
        xfers_q <= xfers_q + 1'b1;
      end
      if (out_valid && !out_ready && (stalls_q != '1)) begin
        stalls_q <= stalls_q + 1'b1;
      end
    end
  end

  assign stat_xfers  = xfers_q;
  assign stat_stalls = stalls_q;
`else
  logic unused_stat_clr;
  assign unused_stat_clr = stat_clr;
  assign stat_xfers      = '0;
  assign stat_stalls     = '0;
`endif

endmodule
